invf_iter: RTL and testbench

//  Multi-cycle reciprocal unit for the 16-bit float format: sign[15], exp[14:7] (bias 127), sig[6:0] with hidden 1.

---
 rtl/invf_iter.sv | 167 ++++++++++++++++
 tb/tb_invf_iter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/invf_iter.sv
// Bit-serial reciprocal z = 1/x for the 16-bit float format (1/8/7, hidden one), one quotient bit per clock.
// Optional build macro INVF_ROUND_EN adds a guard iteration and round-half-up; undefined gives truncation.
module invf_iter #(
    parameter int EXP_W = 8,
    parameter int SIG_W = 7,
    parameter int BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [EXP_W+SIG_W:0]   x,
    output logic                   busy,
    output logic                   valid,
    output logic [EXP_W+SIG_W:0]   z
);
    localparam int W  = EXP_W + SIG_W + 1;
    localparam int Q  = SIG_W + 1;
`ifdef INVF_ROUND_EN
    localparam int N  = Q + 1;
`else
    localparam int N  = Q;
`endif
    localparam int CW = $clog2(Q + 2);

    localparam logic [EXP_W-1:0] EMAX     = '1;
    localparam logic [EXP_W:0]   TWO_BIAS = (EXP_W+1)'(2 * BIAS);
    localparam logic [EXP_W:0]   EZ_K     = (EXP_W+1)'(2 * BIAS - 1);

    typedef enum logic [1:0] {IDLE, FAST, DIV} state_t;

    state_t             state_reg, state_next;
    logic               s_reg, s_next;
    logic [EXP_W-1:0]   e_reg, e_next;
    logic [SIG_W-1:0]   sig_reg, sig_next;
    logic [Q-1:0]       rem_reg, rem_next;
    logic [N-1:0]       q_reg, q_next;
    logic [CW-1:0]      count_reg, count_next;
    logic [W-1:0]       z_reg, z_next;
    logic               valid_reg, valid_next;

    // operand decode, only consumed on the accepting edge
    logic [EXP_W-1:0]   x_e;
    logic [SIG_W-1:0]   x_sig;
    logic               x_fast;

    assign x_e    = x[W-2:SIG_W];
    assign x_sig  = x[SIG_W-1:0];
    assign x_fast = (x_e == '0) || (x_e == EMAX) || (x_sig == '0);

    // fast-path result from the captured operand
    logic [EXP_W:0]     pe;
    logic [W-1:0]       fast_z;

    always_comb begin
        pe     = TWO_BIAS - {1'b0, e_reg};
        fast_z = {s_reg, {(W-1){1'b0}}};
        if (e_reg == '0)
            fast_z = {s_reg, EMAX, {SIG_W{1'b0}}};
        else if (e_reg != EMAX && {1'b0, e_reg} < TWO_BIAS)
            fast_z = {s_reg, pe[EXP_W-1:0], {SIG_W{1'b0}}};
    end

    // one restoring step; remainder always stays below the divisor
    logic [Q-1:0]       m;
    logic [Q:0]         shifted, diff;
    logic               ge;
    logic [Q-1:0]       rem_it;
    logic [N-1:0]       q_it;

    assign m       = {1'b1, sig_reg};
    assign shifted = {rem_reg, 1'b0};
    assign diff    = shifted - {1'b0, m};
    assign ge      = shifted >= {1'b0, m};
    assign rem_it  = ge ? diff[Q-1:0] : shifted[Q-1:0];
    assign q_it    = {q_reg[N-2:0], ge};

    logic [SIG_W-1:0]   sig_fin;
    logic               unused_bits;
`ifdef INVF_ROUND_EN
    logic [N:0]         g_round;
    assign g_round     = {1'b0, q_it} + (N+1)'(1);
    assign sig_fin     = g_round[SIG_W:1];
    assign unused_bits = ^{g_round[N:SIG_W+1], g_round[0], diff[Q]};
`else
    // quotient MSB is always one and is the hidden bit
    assign sig_fin     = q_it[SIG_W-1:0];
    assign unused_bits = ^{q_it[N-1], diff[Q]};
`endif

    logic [EXP_W:0]     ez;
    logic [W-1:0]       div_z;

    assign ez    = EZ_K - {1'b0, e_reg};
    assign div_z = (!ez[EXP_W] && ez != '0) ? {s_reg, ez[EXP_W-1:0], sig_fin}
                                            : {s_reg, {(W-1){1'b0}}};

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        e_next     = e_reg;
        sig_next   = sig_reg;
        rem_next   = rem_reg;
        q_next     = q_reg;
        count_next = count_reg;
        z_next     = z_reg;
        valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    s_next     = x[W-1];
                    e_next     = x_e;
                    sig_next   = x_sig;
                    rem_next   = {1'b1, {SIG_W{1'b0}}};
                    q_next     = '0;
                    count_next = '0;
                    state_next = x_fast ? FAST : DIV;
                end
            end
            FAST: begin
                z_next     = fast_z;
                valid_next = 1'b1;
                state_next = IDLE;
            end
            DIV: begin
                rem_next   = rem_it;
                q_next     = q_it;
                count_next = count_reg + CW'(1);
                if (count_reg == CW'(N - 1)) begin
                    z_next     = div_z;
                    valid_next = 1'b1;
                    count_next = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            s_reg     <= 1'b0;
            e_reg     <= '0;
            sig_reg   <= '0;
            rem_reg   <= '0;
            q_reg     <= '0;
            count_reg <= '0;
            z_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            e_reg     <= e_next;
            sig_reg   <= sig_next;
            rem_reg   <= rem_next;
            q_reg     <= q_next;
            count_reg <= count_next;
            z_reg     <= z_next;
            valid_reg <= valid_next;
        end
    end

    assign busy  = (state_reg != IDLE);
    assign valid = valid_reg;
    assign z     = z_reg;

endmodule

// File: tb/tb_invf_iter.sv
// Directed bench for invf_iter: fast-path specials, divide results, latency, dropped starts and async reset.
module tb_invf_iter;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic        busy;
    logic        valid;
    logic [15:0] z;

    int checks = 0;
    int errors = 0;
    logic [15:0] prev_z;

`ifdef INVF_ROUND_EN
    localparam int          NL   = 9;
    localparam logic [15:0] Z3   = 16'h3EAB;
    localparam logic [15:0] ZM5  = 16'hBE4D;
    localparam logic [15:0] ZMIN = 16'h00AB;
`else
    localparam int          NL   = 8;
    localparam logic [15:0] Z3   = 16'h3EAA;
    localparam logic [15:0] ZM5  = 16'hBE4C;
    localparam logic [15:0] ZMIN = 16'h00AA;
`endif

    invf_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .busy  (busy),
        .valid (valid),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request; returns in the cycle valid is high (edges counted after the accept edge).
    task automatic run_op(input logic [15:0] xv, input logic [15:0] zexp, input int elat, input int inj);
        int lat;
        start = 1'b1;
        x     = xv;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("valid_after_accept", 32'(valid), 32'd0);
        chk("z_holds", 32'(z), 32'(prev_z));
        while (valid !== 1'b1 && lat < 40) begin
            if (lat == inj) begin
                start = 1'b1;
                x     = 16'h4120;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'(elat));
        chk("z_result", 32'(z), 32'(zexp));
        chk("busy_at_valid", 32'(busy), 32'd0);
        prev_z = zexp;
        $display("op x=%h z=%h expected=%h latency=%0d", xv, z, zexp, lat);
    endtask

    initial begin
        int extra;
        rst_n  = 1'b0;
        start  = 1'b0;
        x      = 16'h0000;
        prev_z = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_z", 32'(z), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back sequence: each start is issued in the previous valid cycle
        run_op(16'h4000, 16'h3F00, 1,  -1);
        run_op(16'h4040, Z3,       NL, -1);
        run_op(16'hC0A0, ZM5,      NL, -1);
        run_op(16'h0000, 16'h7F80, 1,  -1);
        run_op(16'h8000, 16'hFF80, 1,  -1);
        run_op(16'h7F80, 16'h0000, 1,  -1);
        run_op(16'hFF80, 16'h8000, 1,  -1);
        run_op(16'h7F40, 16'h0000, NL, -1);
        run_op(16'h7EC0, 16'h0000, NL, -1);
        run_op(16'h7E40, ZMIN,     NL, -1);
        run_op(16'h7E80, 16'h0080, 1,  -1);
        run_op(16'h7F00, 16'h0000, 1,  -1);
        run_op(16'h3F80, 16'h3F80, 1,  -1);

        // a start during the divide must be dropped
        run_op(16'h4040, Z3, NL, 3);
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (valid === 1'b1) extra++;
        end
        chk("single_valid", 32'(extra), 32'd0);

        // async reset three cycles into a divide
        start = 1'b1;
        x     = 16'h4040;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_valid", 32'(valid), 32'd0);
        chk("midreset_z", 32'(z), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        extra = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (valid === 1'b1) extra++;
        end
        chk("no_valid_after_reset", 32'(extra), 32'd0);
        chk("idle_after_reset", 32'(busy), 32'd0);
        prev_z = 16'h0000;
        run_op(16'h3F80, 16'h3F80, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
